// File: rtl/dspl_arbiter.sv
// Display bus arbiter: picks win banner, score view or game digits for the 8-digit display.
// Optional build macro DSPL_SCORE_BCD_EN shows scores as two decimal digits instead of one hex digit.
`timescale 1ns/1ps

module dspl_arbiter #(
  parameter int WIN_CYCLES   = 300_000_000,
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [47:0] game_d,
  input  logic        p1_win,
  input  logic        p2_win,
  input  logic [3:0]  score_p1,
  input  logic [3:0]  score_p2,
  input  logic        score_req,
  output logic [5:0]  d1,
  output logic [5:0]  d2,
  output logic [5:0]  d3,
  output logic [5:0]  d4,
  output logic [5:0]  d5,
  output logic [5:0]  d6,
  output logic [5:0]  d7,
  output logic [5:0]  d8,
  output logic        overlay
);

  localparam int TW = $clog2(WIN_CYCLES);
  // BLINK_CYCLES=1 would give a zero-width counter; keep one bit that never leaves 0.
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [TW-1:0] TIMER_LOAD = TW'(WIN_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
  localparam logic [5:0]    BLANK      = 6'b000000;

  typedef enum logic [1:0] {
    ST_GAME  = 2'd0,
    ST_SCORE = 2'd1,
    ST_WIN   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          phase_q, phase_d;
  logic [1:0]    winner_q, winner_d;
  logic [47:0]   disp_q, disp_d;
  logic          overlay_q, overlay_d;

  function automatic logic [5:0] hex_digit(input logic [3:0] value);
    return {1'b1, value, 1'b0};
  endfunction

`ifdef DSPL_SCORE_BCD_EN
  // Two decimal digits {tens, ones}; tens stays lit even when zero.
  function automatic logic [11:0] dec_pair(input logic [3:0] value);
    logic       tens;
    logic [3:0] ones;
    tens = (value > 4'd9);
    ones = tens ? (value - 4'd10) : value;
    return {hex_digit({3'b000, tens}), hex_digit(ones)};
  endfunction

  function automatic logic [23:0] score_field(input logic [3:0] s1, input logic [3:0] s2);
    return {dec_pair(s1), dec_pair(s2)};
  endfunction
`else
  function automatic logic [23:0] score_field(input logic [3:0] s1, input logic [3:0] s2);
    return {BLANK, hex_digit(s1), BLANK, hex_digit(s2)};
  endfunction
`endif

  logic [23:0] field;
  assign field = score_field(score_p1, score_p2);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    timer_d   = timer_q;
    blink_d   = blink_q;
    phase_d   = phase_q;
    winner_d  = winner_q;
    disp_d    = game_d;
    overlay_d = 1'b0;

    if (p1_win || p2_win) begin
      // A pulse always (re)starts the banner, even while one is already running.
      state_d  = ST_WIN;
      timer_d  = TIMER_LOAD;
      blink_d  = '0;
      phase_d  = 1'b1;
      winner_d = (p1_win && p2_win) ? 2'd3 : (p1_win ? 2'd1 : 2'd2);
    end else begin
      case (state_q)
        ST_WIN: begin
          if (timer_q == '0) begin
            state_d = score_req ? ST_SCORE : ST_GAME;
          end else begin
            timer_d = timer_q - 1'b1;
            if (blink_q == BLINK_LAST) begin
              blink_d = '0;
              phase_d = ~phase_q;
            end else begin
              blink_d = blink_q + 1'b1;
            end
          end
        end
        default: state_d = score_req ? ST_SCORE : ST_GAME;
      endcase
    end

    // Output image is built from the next state so it lands on the same edge.
    case (state_d)
      ST_WIN: begin
        disp_d    = {phase_d ? {4{hex_digit({2'b00, winner_d})}} : {4{BLANK}}, field};
        overlay_d = 1'b1;
      end
      ST_SCORE: begin
        disp_d    = {{4{BLANK}}, field};
        overlay_d = 1'b1;
      end
      default: begin
        disp_d    = game_d;
        overlay_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    if (!reset) begin
      state_q   <= ST_GAME;
      timer_q   <= '0;
      blink_q   <= '0;
      phase_q   <= 1'b0;
      winner_q  <= 2'd0;
      disp_q    <= '0;
      overlay_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      blink_q   <= blink_d;
      phase_q   <= phase_d;
      winner_q  <= winner_d;
      disp_q    <= disp_d;
      overlay_q <= overlay_d;
    end
  end

  assign d1      = disp_q[5:0];
  assign d2      = disp_q[11:6];
  assign d3      = disp_q[17:12];
  assign d4      = disp_q[23:18];
  assign d5      = disp_q[29:24];
  assign d6      = disp_q[35:30];
  assign d7      = disp_q[41:36];
  assign d8      = disp_q[47:42];
  assign overlay = overlay_q;

endmodule

// File: tb/tb_dspl_arbiter.sv
// Bench for dspl_arbiter: vector table for reset/pass-through/score view, plus banner sequences
// (blink, tie, retrigger, score_req at expiry, reset mid-banner) checked through an expected-output queue.
`timescale 1ns/1ps

module tb_dspl_arbiter;

  localparam int WIN   = 20;
  localparam int BLINK = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [47:0] game_d;
  logic        p1_win, p2_win;
  logic [3:0]  score_p1, score_p2;
  logic        score_req;
  logic [5:0]  d1, d2, d3, d4, d5, d6, d7, d8;
  logic        overlay;

  always #5 clock = ~clock;

  dspl_arbiter #(.WIN_CYCLES(WIN), .BLINK_CYCLES(BLINK)) dut (
    .clock(clock), .reset(reset), .game_d(game_d),
    .p1_win(p1_win), .p2_win(p2_win),
    .score_p1(score_p1), .score_p2(score_p2), .score_req(score_req),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7), .d8(d8),
    .overlay(overlay)
  );

  typedef struct {
    logic        rst_n;
    logic [47:0] game;
    logic        p1, p2;
    logic [3:0]  s1, s2;
    logic        req;
    logic [47:0] exp_d;
    logic        exp_ov;
  } vec_t;

  typedef struct {
    logic [47:0] d;
    logic        ov;
    int          tag;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  localparam logic [47:0] G_ONES = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] G1     = 48'h1234_5678_9ABC;
  localparam logic [47:0] G2     = 48'hA5A5_0F0F_C3C3;
  localparam logic [47:0] G3     = 48'h0000_0000_0041;

  function automatic logic [5:0] dig(input logic [3:0] h);
    return {1'b1, h, 1'b0};
  endfunction

  // Expected d4..d1 for the build under test.
  function automatic logic [23:0] field(input logic [3:0] a, input logic [3:0] b);
`ifdef DSPL_SCORE_BCD_EN
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    return {dig(4'(ia / 10)), dig(4'(ia % 10)), dig(4'(ib / 10)), dig(4'(ib % 10))};
`else
    return {6'd0, dig(a), 6'd0, dig(b)};
`endif
  endfunction

  function automatic vec_t mk(input logic rst_n, input logic [47:0] game, input logic p1, input logic p2,
                              input logic [3:0] s1, input logic [3:0] s2, input logic req,
                              input logic [47:0] exp_d, input logic exp_ov);
    vec_t v;
    v.rst_n = rst_n; v.game = game; v.p1 = p1; v.p2 = p2;
    v.s1 = s1; v.s2 = s2; v.req = req; v.exp_d = exp_d; v.exp_ov = exp_ov;
    return v;
  endfunction

  task automatic check_out();
    exp_t        e;
    logic [47:0] act;
    act = {d8, d7, d6, d5, d4, d3, d2, d1};
    n_vec++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: output d=%h ov=%b with nothing expected", act, overlay);
    end else begin
      e = sb.pop_front();
      if (act !== e.d || overlay !== e.ov) begin
        n_fail++;
        $display("FAIL vec_%0d: got d=%h ov=%b, expected d=%h ov=%b", e.tag, act, overlay, e.d, e.ov);
      end
    end
  endtask

  // Called at a negedge: drive, queue the expectation, sample at the following negedge.
  task automatic apply(input vec_t v, input int tag);
    reset     = v.rst_n;
    game_d    = v.game;
    p1_win    = v.p1;
    p2_win    = v.p2;
    score_p1  = v.s1;
    score_p2  = v.s2;
    score_req = v.req;
    sb.push_back('{d: v.exp_d, ov: v.exp_ov, tag: tag});
    @(posedge clock);
    @(negedge clock);
    check_out();
  endtask

  // Banner run: first pulse at k=0 (p1a/p2a), optional second pulse at rt_k (p1b/p2b).
  // score_req is high for k in [req_from, req_to]; score_p1 steps from 3 to 9 at k=8.
  task automatic banner_seq(input logic p1a, input logic p2a, input int rt_k, input logic p1b,
                            input logic p2b, input int req_from, input int req_to, input int n,
                            input logic [47:0] g, input int tag_base);
    for (int k = 0; k < n; k++) begin
      logic        p1, p2, req;
      logic [3:0]  s1;
      logic [1:0]  w;
      logic [23:0] ban;
      logic [47:0] ed;
      logic        eo;
      int          last, age;
      p1   = (k == 0) ? p1a : ((k == rt_k) ? p1b : 1'b0);
      p2   = (k == 0) ? p2a : ((k == rt_k) ? p2b : 1'b0);
      req  = (k >= req_from) && (k <= req_to);
      s1   = (k < 8) ? 4'd3 : 4'd9;
      last = (rt_k > 0 && k >= rt_k) ? rt_k : 0;
      age  = k - last;
      if (last == 0) w = (p1a && p2a) ? 2'd3 : (p1a ? 2'd1 : 2'd2);
      else           w = (p1b && p2b) ? 2'd3 : (p1b ? 2'd1 : 2'd2);
      if (age < WIN) begin
        ban = (((age / BLINK) % 2) == 0) ? {4{dig({2'b00, w})}} : 24'd0;
        ed  = {ban, field(s1, 4'd5)};
        eo  = 1'b1;
      end else if (req) begin
        ed = {24'd0, field(s1, 4'd5)};
        eo = 1'b1;
      end else begin
        ed = g;
        eo = 1'b0;
      end
      apply(mk(1'b1, g, p1, p2, s1, 4'd5, req, ed, eo), tag_base + k);
    end
  endtask

  vec_t tbl[11];

  initial begin
    reset = 1'b0; game_d = G_ONES; p1_win = 1'b0; p2_win = 1'b0;
    score_p1 = 4'd0; score_p2 = 4'd0; score_req = 1'b0;

    tbl[0]  = mk(1'b0, G_ONES, 1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 48'd0, 1'b0);
    tbl[1]  = mk(1'b0, G_ONES, 1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 48'd0, 1'b0);
    tbl[2]  = mk(1'b0, G_ONES, 1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 48'd0, 1'b0);
    tbl[3]  = mk(1'b1, G1,     1'b0, 1'b0, 4'd0,  4'd0,  1'b0, G1,    1'b0);
    tbl[4]  = mk(1'b1, G2,     1'b0, 1'b0, 4'd3,  4'd5,  1'b0, G2,    1'b0);
    tbl[5]  = mk(1'b1, G2,     1'b0, 1'b0, 4'd3,  4'd5,  1'b1, {24'd0, field(4'd3, 4'd5)}, 1'b1);
    tbl[6]  = mk(1'b1, G2,     1'b0, 1'b0, 4'd12, 4'd7,  1'b1, {24'd0, field(4'd12, 4'd7)}, 1'b1);
    tbl[7]  = mk(1'b1, G2,     1'b0, 1'b0, 4'd0,  4'd15, 1'b1, {24'd0, field(4'd0, 4'd15)}, 1'b1);
    tbl[8]  = mk(1'b1, G3,     1'b0, 1'b0, 4'd0,  4'd15, 1'b0, G3,    1'b0);
    tbl[9]  = mk(1'b1, G3,     1'b0, 1'b0, 4'd9,  4'd9,  1'b1, {24'd0, field(4'd9, 4'd9)}, 1'b1);
    tbl[10] = mk(1'b0, G3,     1'b0, 1'b0, 4'd9,  4'd9,  1'b1, 48'd0, 1'b0);

    @(negedge clock);
    for (int i = 0; i < 11; i++) apply(tbl[i], i);

    // p1 wins: blink, score change mid-banner, score_req pulse ignored, expiry back to game.
    banner_seq(1'b1, 1'b0, -1, 1'b0, 1'b0, 5, 8, WIN + 2, G1, 100);
    // Tie.
    banner_seq(1'b1, 1'b1, -1, 1'b0, 1'b0, 1, 0, WIN + 1, G2, 200);
    // Retrigger by p2 at cycle 10: banner ends 30 cycles after first entry.
    banner_seq(1'b1, 1'b0, 10, 1'b0, 1'b1, 1, 0, WIN + 12, G3, 300);
    // score_req held across expiry lands in SCORE, then dropping it returns to game.
    banner_seq(1'b0, 1'b1, -1, 1'b0, 1'b0, 0, 1000, WIN + 3, G1, 400);
    apply(mk(1'b1, G1, 1'b0, 1'b0, 4'd9, 4'd5, 1'b0, G1, 1'b0), 450);
    // Reset mid-banner aborts at once.
    banner_seq(1'b1, 1'b0, -1, 1'b0, 1'b0, 1, 0, 6, G2, 500);
    apply(mk(1'b0, G2, 1'b0, 1'b0, 4'd9, 4'd5, 1'b0, 48'd0, 1'b0), 550);
    apply(mk(1'b0, G2, 1'b1, 1'b0, 4'd9, 4'd5, 1'b1, 48'd0, 1'b0), 551);
    apply(mk(1'b1, G2, 1'b0, 1'b0, 4'd9, 4'd5, 1'b0, G2, 1'b0), 552);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
